// File: rtl/serial_char_rx.sv
// Serial character receiver: start bit, 7 data bits (LSB first), optional parity, stop bit.
// Good characters are presented on char with a one-clock char_valid strobe; bad frames are dropped.
module serial_char_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [6:0] char,
    output logic       char_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [6:0]    char_q, char_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          sample;
    logic          stop_hit;
    logic          parity_ok;

    // Start bit is sampled half a bit in; every later bit one full bit after the previous sample.
    assign sample    = (state_q == S_START) ? (tick_q == HALF_TICK) : (tick_q == LAST_TICK);
    assign stop_hit  = (state_q == S_STOP) && sample;
    assign parity_ok = !PARITY_EN || (par_q == PARITY_ODD);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            char_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!rx_s_q) state_d = S_START;
            S_START:  if (sample) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:   if (sample && bit_q == 3'd6) state_d = PARITY_EN ? S_PARITY : S_STOP;
            S_PARITY: if (sample) state_d = S_STOP;
            S_STOP:   if (sample) state_d = rx_s_q ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick_d  = tick_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == S_IDLE || state_q == S_BREAK || sample) begin
            tick_d = '0;
        end
        if (state_q != S_DATA) begin
            bit_d = '0;
        end else if (sample) begin
            bit_d   = bit_q + 3'd1;
            shift_d = {rx_s_q, shift_q[6:1]};
        end
        // Running XOR over data and parity bits; held until the stop sample.
        if (state_q == S_IDLE) begin
            par_d = 1'b0;
        end else if ((state_q == S_DATA || state_q == S_PARITY) && sample) begin
            par_d = par_q ^ rx_s_q;
        end
        valid_d = stop_hit && rx_s_q && parity_ok;
        perr_d  = stop_hit && rx_s_q && !parity_ok;
        ferr_d  = stop_hit && !rx_s_q;
        char_d  = valid_d ? shift_q : char_q;
    end

    assign char       = char_q;
    assign char_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE) || valid_q || perr_q || ferr_q;

endmodule

// File: tb/tb_serial_char_rx.sv
// Bench for serial_char_rx: a parity instance and a no-parity instance, each with a pulse scoreboard.
module tb_serial_char_rx;
    localparam int C = 16;
    localparam int H = C / 2;

    typedef enum int {EV_CHAR, EV_PERR, EV_FERR} ev_t;
    typedef struct {
        ev_t        kind;
        logic [6:0] ch;
        int         at;
    } exp_t;
    typedef struct {
        logic [6:0] data;
        bit         flip_par;
        logic [6:0] exp_char;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_np;
    logic [6:0] ch, ch_np;
    logic       cv, pe, fe, bz;
    logic       cv_np, pe_np, fe_np, bz_np;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       sb[$];
    exp_t       sb_np[$];
    vec_t       tbl[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_char_rx dut (
        .clk(clk), .reset(reset), .rx(rx), .char(ch), .char_valid(cv),
        .parity_err(pe), .frame_err(fe), .busy(bz)
    );

    serial_char_rx #(.PARITY_EN(1'b0)) dut_np (
        .clk(clk), .reset(reset), .rx(rx_np), .char(ch_np), .char_valid(cv_np),
        .parity_err(pe_np), .frame_err(fe_np), .busy(bz_np)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor(input bit np);
        exp_t       e;
        logic [6:0] prev_ch;
        logic [6:0] c;
        logic [2:0] pulses;
        logic [2:0] want;
        int         pending;
        string      tag;
        prev_ch = '0;
        tag = np ? "np" : "par";
        forever begin
            @(negedge clk);
            c      = np ? ch_np : ch;
            pulses = np ? {cv_np, pe_np, fe_np} : {cv, pe, fe};
            if (reset) begin
                if (!pulses[2] && c !== prev_ch)
                    check({tag, " char moved without char_valid"}, c, prev_ch);
                if (pulses != 3'b000) begin
                    check({tag, " single pulse"}, $countones(pulses), 1);
                    pending = np ? sb_np.size() : sb.size();
                    if (pending == 0) begin
                        check({tag, " unexpected pulse"}, pulses, 0);
                    end else begin
                        if (np) e = sb_np.pop_front();
                        else    e = sb.pop_front();
                        want = (e.kind == EV_CHAR) ? 3'b100 : (e.kind == EV_PERR) ? 3'b010 : 3'b001;
                        check({tag, " pulse kind"}, pulses, want);
                        check({tag, " pulse cycle"}, cyc, e.at);
                        if (e.kind == EV_CHAR) check({tag, " char value"}, c, e.ch);
                    end
                end
            end
            prev_ch = c;
        end
    endtask

    task automatic drive(input bit np, input logic b);
        if (np) rx_np = b;
        else    rx = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; expectation derived from frame timing plus 2-flop sync.
    task automatic send_frame(input bit np, input logic [6:0] d, input bit flip,
                              input logic stop_b, input bit track);
        exp_t e;
        e.at = cyc + 3 + H + (np ? 8 : 9) * C;
        e.ch = d;
        if (!stop_b)          e.kind = EV_FERR;
        else if (!np && flip) e.kind = EV_PERR;
        else                  e.kind = EV_CHAR;
        if (track) begin
            if (np) sb_np.push_back(e);
            else    sb.push_back(e);
        end
        drive(np, 1'b0);
        for (int i = 0; i < 7; i++) drive(np, d[i]);
        if (!np) drive(np, (^d) ^ flip);
        drive(np, stop_b);
    endtask

    task automatic idle(input int n);
        rx    = 1'b1;
        rx_np = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit np);
        int n;
        n = 0;
        while ((np ? sb_np.size() : sb.size()) != 0 && n < 20 * C) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(np ? "np scoreboard drained" : "par scoreboard drained",
              np ? sb_np.size() : sb.size(), 0);
    endtask

    task automatic at_neg(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " char"}, ch, 7'h00);
        check({tag, " char_valid"}, cv, 1'b0);
        check({tag, " parity_err"}, pe, 1'b0);
        check({tag, " frame_err"}, fe, 1'b0);
        check({tag, " busy"}, bz, 1'b0);
    endtask

    initial begin
        int k;
        tbl = '{
            '{7'h58, 1'b0, 7'h58},
            '{7'h6B, 1'b1, 7'h58},
            '{7'h00, 1'b0, 7'h00},
            '{7'h7F, 1'b1, 7'h00},
            '{7'h7F, 1'b0, 7'h7F},
            '{7'h2A, 1'b0, 7'h2A},
            '{7'h55, 1'b1, 7'h2A}
        };
        reset = 1'b0;
        rx    = 1'b1;
        rx_np = 1'b1;
        fork
            monitor(1'b0);
            monitor(1'b1);
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2 * C);

        // Good and bad-parity frames; char must hold through dropped ones.
        for (int i = 0; i < 7; i++) begin
            send_frame(1'b0, tbl[i].data, tbl[i].flip_par, 1'b1, 1'b1);
            drain(1'b0);
            check("char after table frame", ch, tbl[i].exp_char);
            idle(2 * C);
        end

        // Stop bit low, line held low: one frame_err, busy through the break.
        send_frame(1'b0, 7'h28, 1'b0, 1'b0, 1'b1);
        repeat (3 * C) @(posedge clk);
        #1;
        check("busy during break", bz, 1'b1);
        rx = 1'b1;
        k = cyc;
        at_neg(k + 2);
        check("busy until rx_s high", bz, 1'b1);
        at_neg(k + 3);
        check("busy clears after break", bz, 1'b0);
        @(posedge clk);
        #1;
        idle(C);
        send_frame(1'b0, 7'h23, 1'b0, 1'b1, 1'b1);
        drain(1'b0);
        check("char after break", ch, 7'h23);
        idle(2 * C);

        // Short low glitch in idle: false start, no pulses.
        k = cyc;
        rx = 1'b0;
        repeat (C / 4) @(posedge clk);
        #1;
        rx = 1'b1;
        at_neg(k + 3);
        check("busy after glitch start", bz, 1'b1);
        at_neg(k + 2 + H);
        check("busy before start sample", bz, 1'b1);
        at_neg(k + 3 + H);
        check("busy after false start", bz, 1'b0);
        @(posedge clk);
        #1;
        idle(2 * C);
        check("no pulse pending after glitch", sb.size(), 0);

        // Back-to-back frames on both instances.
        send_frame(1'b0, 7'h58, 1'b0, 1'b1, 1'b1);
        send_frame(1'b0, 7'h6B, 1'b0, 1'b1, 1'b1);
        send_frame(1'b0, 7'h32, 1'b0, 1'b1, 1'b1);
        drain(1'b0);
        check("char after back-to-back", ch, 7'h32);
        send_frame(1'b1, 7'h58, 1'b0, 1'b1, 1'b1);
        send_frame(1'b1, 7'h6B, 1'b0, 1'b1, 1'b1);
        send_frame(1'b1, 7'h32, 1'b0, 1'b1, 1'b1);
        drain(1'b1);
        check("np char after back-to-back", ch_np, 7'h32);
        idle(2 * C);

        // Reset in the middle of data bit 3; remainder of that frame stays high.
        fork
            send_frame(1'b0, 7'h79, 1'b0, 1'b1, 1'b0);
            begin
                repeat (4 * C + H) @(posedge clk);
                #1;
                reset = 1'b0;
                #1;
                check_all_zero("mid-frame reset");
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
            end
        join
        idle(2 * C);
        check("no pulse from aborted frame", sb.size(), 0);
        send_frame(1'b0, 7'h32, 1'b0, 1'b1, 1'b1);
        drain(1'b0);
        check("char after reset recovery", ch, 7'h32);
        idle(C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
